alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the multi-cycle CPU datapath; successor of the 3-bit-opcode combinational ALU.
- Generalises the datapath width and extends the opcode to 4 bits. Keeps the eight legacy logic/arith ops and adds a variable shift amount, SRA and SLTU.
- Adds iterative multiply and divide, which take WIDTH cycles each.
- Operands enter and the result leaves through valid/ready handshakes, so the control FSM can stall on long ops.

Parameters:
- WIDTH, 32, operand/result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), derived shift-amount width; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block accepts operands this cycle.
- Adat  in  WIDTH  operand A (shift amount source for shifts).
- Bdat  in  WIDTH  operand B.
- ALUop  in  4  operation code.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (ADD/SUB only, else 0).
- dbz  out  1  divide by zero on DIVU/REMU.
- illegal  out  1  unsupported op code.

Behaviour:
- Reset (rst_n low, any time, including mid-operation): state IDLE; result=0; zero, overflow, dbz, illegal, out_valid=0; iteration counter=0; in_ready=0 while in reset; any in-flight op is discarded.
- Op codes (legacy encodings preserved):
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0110 SUB; 0111 SLT signed.
  - 0101 SRL = Bdat >> Adat[SHW-1:0].
  - 1000 SRA arithmetic: Bdat >>> Adat[SHW-1:0].
  - 1001 SLTU unsigned.
  - 1010 MUL: low WIDTH bits of unsigned product. 1011 MULHU: high WIDTH bits.
  - 1100 DIVU: quotient. 1101 REMU: remainder.
  - 1110, 1111: illegal.
- States IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid, latch operands and op.
    - Single-cycle ops and illegal codes go to DONE; the result is registered, so out_valid rises the cycle after acceptance (latency 1).
    - MUL/MULHU/DIVU/REMU go to BUSY with counter=0.
  - BUSY: in_ready=0. One iteration per cycle: shift-add multiply, restoring divide.
    - Go to DONE when counter==WIDTH-1; latency is WIDTH+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1; result and flags held stable. On out_ready go to IDLE; out_valid drops the next cycle.
    - in_ready stays 0 in DONE. Back-to-back issue therefore costs one idle cycle; this is intentional.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH. overflow is set when the operand signs make signed overflow.
  - SLT/SLTU produce zero-extended 0 or 1.
  - Shift amount uses only the low SHW bits of Adat.
- Divide by zero: DIVU gives all-ones, REMU gives Adat, dbz=1. The op still takes WIDTH+1 cycles.
- Illegal op: result=0, illegal=1, zero=1, 1-cycle latency.
- zero is computed from the registered result. Flags update only on the DONE entry transition.
- Changing in_valid or operands while BUSY has no effect.

Optional Feature:
- ALU_MC_MULDIV_EN.
- Defined: MUL/MULHU/DIVU/REMU are implemented as above.
- Undefined: codes 1010–1101 are treated as illegal (illegal=1, result=0, latency 1). The BUSY state, counter and partial-product/remainder registers are not synthesised.

Decomposition:
- Shared package alu_mc_pkg holds the 4-bit op-code localparams (OP_AND…OP_REMU) and the state encoding (ST_IDLE, ST_BUSY, ST_DONE), so the control FSM can decode the same names.
- One sub-module, alu_mc_iter (sequential shift-add/restoring-divide engine with start/done), instantiated only under ALU_MC_MULDIV_EN.

Test Plan:
- Reset asserted while BUSY on MUL 7×9 → out_valid=0, result=0 immediately (async); after release, in_ready=1 and the next ADD works.
- ADD 0x7FFFFFFF+1 → out_valid after 1 cycle; result=0x80000000, overflow=1. SUB 5−5 → result=0, zero=1, overflow=0.
- SRA Adat=4, Bdat=0xF0000000 → 0xFF000000. SRL same inputs → 0x0F000000. SLT −1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result 0xFFFFFFFE after 33 cycles. MUL same inputs → 0x00000001. in_ready=0 throughout BUSY.
- DIVU 100/7 → 14; REMU → 2. DIVU 5/0 → 0xFFFFFFFF, dbz=1. REMU 5/0 → 5, dbz=1.
- out_ready held low 10 cycles in DONE → result stable and in_ready=0; then pulse out_ready → IDLE. Op 1111 → illegal=1, result=0. Without the macro, op 1010 → illegal=1 with latency 1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op-code encodings and FSM states.
// The control FSM and the ALU decode the same names from here.
package alu_mc_pkg;

    // Legacy 3-bit encodings keep their values in the low bits.
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the ops served by the iterative engine.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative engine: shift-add unsigned multiply and restoring unsigned divide.
// Loaded on start, performs one iteration per step cycle for WIDTH steps.
// 'last' flags the final step; lo_nx/hi_nx are the values that step produces,
// so the caller can register the answer on the same edge.
//   multiply: {hi,lo} = product            (lo = low half, hi = high half)
//   divide  : lo = quotient, hi = remainder
// A zero divisor needs no special case: every trial subtract succeeds, giving
// an all-ones quotient and the dividend as remainder.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic             last,
    output logic [WIDTH-1:0] lo_nx,
    output logic [WIDTH-1:0] hi_nx,
    output logic             dbz
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    // One iteration of either algorithm, plus load/advance of the registers.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, opnd_q});
        rem_sub = rem_sh[WIDTH-1:0] - opnd_q;

        if (is_div_q) begin
            hi_nx = ge ? rem_sub : rem_sh[WIDTH-1:0];
            lo_nx = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo_q[WIDTH-1:1]};
        end

        last = step && (cnt_q == SHW'(WIDTH - 1));
        dbz  = is_div_q && (opnd_q == '0);

        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        if (start) begin
            hi_d     = '0;
            lo_d     = is_div ? a : b;
            opnd_d   = is_div ? b : a;
            is_div_d = is_div;
            cnt_d    = '0;
        end else if (step) begin
            hi_d  = hi_nx;
            lo_d  = lo_nx;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready operand and result handshakes.
// Optional feature macro: ALU_MC_MULDIV_EN enables MUL/MULHU/DIVU/REMU through
// the iterative engine; without it those codes are reported as illegal.
//
// Handshake: an operand set is taken on a clock edge where in_valid && in_ready;
// a result is released on an edge where out_valid && out_ready. in_ready is high
// only in IDLE, out_valid only in DONE, so the two never overlap and the block
// holds exactly one operation at a time.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Adat,
    input  logic [WIDTH-1:0] Bdat,
    input  logic [3:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             dbz,
    output logic             illegal
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [SHW-1:0]   sh;

    // Held low during reset so nothing is accepted while the block is cleared.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign dbz       = dbz_q;
    assign illegal   = ill_q;

`ifdef ALU_MC_MULDIV_EN
    logic             sel_hi_q, sel_hi_d;
    logic             iter_start;
    logic             iter_last;
    logic             iter_dbz;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;

    assign iter_start = in_valid && in_ready && is_muldiv(ALUop);

    alu_mc_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .is_div (ALUop[2]),
        .a      (Adat),
        .b      (Bdat),
        .step   (state_q == ST_BUSY),
        .last   (iter_last),
        .lo_nx  (iter_lo),
        .hi_nx  (iter_hi),
        .dbz    (iter_dbz)
    );
`endif

    // Single-cycle datapath: result, overflow and legality for the current op.
    always_comb begin
        sh      = Adat[SHW-1:0];
        add_res = Adat + Bdat;
        sub_res = Adat - Bdat;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ALUop)
            OP_AND:  alu_res = Adat & Bdat;
            OP_OR:   alu_res = Adat | Bdat;
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (Adat[WIDTH-1] == Bdat[WIDTH-1]) && (add_res[WIDTH-1] != Adat[WIDTH-1]);
            end
            OP_XOR:  alu_res = Adat ^ Bdat;
            OP_NOR:  alu_res = ~(Adat | Bdat);
            OP_SRL:  alu_res = Bdat >> sh;
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (Adat[WIDTH-1] != Bdat[WIDTH-1]) && (sub_res[WIDTH-1] != Adat[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(Adat) < $signed(Bdat))};
            OP_SRA:  alu_res = $unsigned($signed(Bdat) >>> sh);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (Adat < Bdat)};
            default: alu_ill = 1'b1;
        endcase
    end

    // Control FSM next state; result and flags change only when entering DONE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
`ifdef ALU_MC_MULDIV_EN
        sel_hi_d = sel_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_MC_MULDIV_EN
                    if (is_muldiv(ALUop)) begin
                        state_d  = ST_BUSY;
                        sel_hi_d = ALUop[0];
                    end else begin
`endif
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        dbz_d    = 1'b0;
                        ill_d    = alu_ill;
`ifdef ALU_MC_MULDIV_EN
                    end
`endif
                end
            end
`ifdef ALU_MC_MULDIV_EN
            ST_BUSY: begin
                if (iter_last) begin
                    state_d  = ST_DONE;
                    result_d = sel_hi_q ? iter_hi : iter_lo;
                    zero_d   = ((sel_hi_q ? iter_hi : iter_lo) == '0);
                    ovf_d    = 1'b0;
                    dbz_d    = iter_dbz;
                    ill_d    = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
    end

    // Control and output registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
            sel_hi_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MC_MULDIV_EN
            sel_hi_q    <= sel_hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc (WIDTH=32): table of vectors through a scoreboard queue,
// plus hand-written sequences for reset mid-operation and a long result stall.
module tb_alu_mc;

    localparam int W   = 32;
    localparam int LAT_ITER = W + 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Adat;
    logic [W-1:0] Bdat;
    logic [3:0]   ALUop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         dbz;
    logic         illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         dbz;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Adat      (Adat),
        .Bdat      (Bdat),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .dbz       (dbz),
        .illegal   (illegal)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Builds one vector; without the mul/div feature those codes are illegal.
    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic ovf, input logic dz,
                                input logic ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.ovf = ovf; v.dbz = dz; v.ill = ill; v.lat = lat;
`ifndef ALU_MC_MULDIV_EN
        if (op inside {4'hA, 4'hB, 4'hC, 4'hD}) begin
            v.res = '0; v.ovf = 1'b0; v.dbz = 1'b0; v.ill = 1'b1; v.lat = 1;
        end
`endif
        return v;
    endfunction

    // Driver + checker for one operation; result is held 'hold' cycles before out_ready.
    task automatic run_op(input vec_t v, input int hold);
        vec_t e;
        int   lat;
        int   waitc;
        int   rdy_bad;
        logic [W-1:0] held;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(v);
        ALUop    = v.op;
        Adat     = v.a;
        Bdat     = v.b;
        in_valid = 1'b1;
        lat      = 0;
        rdy_bad  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            // Junk on the inputs while busy must not disturb the operation.
            in_valid = 1'($urandom_range(0, 1));
            Adat     = $urandom;
            Bdat     = $urandom;
            ALUop    = 4'($urandom_range(0, 15));
            if (!out_valid && in_ready) rdy_bad++;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        chk($sformatf("out_valid_seen op=%h", e.op), {31'd0, out_valid}, 32'd1);
        chk($sformatf("latency op=%h", e.op), lat, e.lat);
        chk($sformatf("result op=%h a=%h b=%h", e.op, e.a, e.b), result, e.res);
        chk($sformatf("zero op=%h", e.op), {31'd0, zero}, {31'd0, (e.res == '0)});
        chk($sformatf("overflow op=%h", e.op), {31'd0, overflow}, {31'd0, e.ovf});
        chk($sformatf("dbz op=%h", e.op), {31'd0, dbz}, {31'd0, e.dbz});
        chk($sformatf("illegal op=%h", e.op), {31'd0, illegal}, {31'd0, e.ill});
        chk($sformatf("in_ready_low_busy op=%h", e.op), rdy_bad, 0);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall_result_stable", result, e.res);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_handshake_out_valid", {31'd0, out_valid}, 32'd0);
        chk("after_handshake_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_handshake_result_held", result, held);
    endtask

    initial begin
        // Clock/reset block.
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Adat      = '0;
        Bdat      = '0;
        ALUop     = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {28'd0, zero, overflow, dbz, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Vector table.
        vecs.push_back(mk(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0, 0, 0, 1));
        vecs.push_back(mk(4'h1, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0, 0, 0, 1));
        vecs.push_back(mk(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 0, 0, 1));
        vecs.push_back(mk(4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h2, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 0, 0, 1));
        vecs.push_back(mk(4'h3, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0, 0, 0, 1));
        vecs.push_back(mk(4'h4, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1));
        vecs.push_back(mk(4'h6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h6, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 0, 0, 1));
        vecs.push_back(mk(4'h6, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 0, 0, 0, 1));
        vecs.push_back(mk(4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 1));
        vecs.push_back(mk(4'h7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 1));
        vecs.push_back(mk(4'h5, 32'h0000_0004, 32'hF000_0000, 32'h0F00_0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h5, 32'h0000_0024, 32'hF000_0000, 32'h0F00_0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h8, 32'h0000_0004, 32'hF000_0000, 32'hFF00_0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h8, 32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1));
        vecs.push_back(mk(4'h8, 32'h0000_0004, 32'h7000_0000, 32'h0700_0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hA, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hB, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hC, 32'd100,       32'd7,         32'd14,        0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hD, 32'd100,       32'd7,         32'd2,         0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hC, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 1, 0, LAT_ITER));
        vecs.push_back(mk(4'hD, 32'd5,         32'd0,         32'd5,         0, 1, 0, LAT_ITER));
        vecs.push_back(mk(4'hC, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hD, 32'd7,         32'd100,       32'd7,         0, 0, 0, LAT_ITER));
        vecs.push_back(mk(4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 0, 0, 1, 1));
        vecs.push_back(mk(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 1, 1));

        foreach (vecs[i]) run_op(vecs[i], $urandom_range(0, 2));

        // Long stall in DONE on a multi-cycle op and on a single-cycle op.
        run_op(mk(4'hC, 32'd100, 32'd7, 32'd14, 0, 0, 0, LAT_ITER), 10);
        run_op(mk(4'h6, 32'd5, 32'd5, 32'd0, 0, 0, 0, 1), 10);
        // Non-zero result left in place so the reset below has something to clear.
        run_op(mk(4'h2, 32'd40, 32'd2, 32'd42, 0, 0, 0, 1), 0);

        // Reset asserted a few cycles into MUL 7x9.
        ALUop    = 4'hA;
        Adat     = 32'd7;
        Bdat     = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midop_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midop_reset_result", result, 32'd0);
        chk("midop_reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midop_reset_flags", {28'd0, zero, overflow, dbz, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midop_release_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("midop_no_stale_result", {31'd0, out_valid}, 32'd0);
        run_op(mk(4'h2, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1), 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
